// File: rtl/cordic_seq.sv
// cordic_seq: iterative CORDIC engine with a single shared shift-add datapath.
// One operand set (x, y, z) is accepted through a valid/ready handshake. ITER
// micro-rotations then run, one per clock, with shift amount i = 0..ITER-1.
// The result is returned through a second valid/ready handshake.
// Rotation mode (mode=0) drives z toward 0; vectoring mode (mode=1) drives y
// toward 0. No gain compensation: x/y carry the CORDIC gain (~1.64676).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (highest priority)
//   abort             synchronous cancel back to IDLE; data registers kept
//   in_valid/in_ready operand handshake; in_ready is high only in IDLE
//   mode              0 = rotation, 1 = vectoring; captured on accept
//   x_in, y_in, z_in  signed Q3.(N-3) operands
//   atan_addr         iteration index to the arctangent ROM (0 outside RUN)
//   atan_data         atan(2^-i) in Q3.(N-3), combinational, same cycle
//   out_valid/out_ready result handshake; results frozen while out_valid=1
//   x_out, y_out, z_out signed results
//   busy              high in RUN or DONE
module cordic_seq #(
  parameter int N    = 32,
  parameter int ITER = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                abort,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic signed [N-1:0] x_in,
  input  logic signed [N-1:0] y_in,
  input  logic signed [N-1:0] z_in,
  output logic [4:0]          atan_addr,
  input  logic signed [N-1:0] atan_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] x_out,
  output logic signed [N-1:0] y_out,
  output logic signed [N-1:0] z_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_t              state_q, state_d;
  logic [4:0]          i_q, i_d;
  logic                mode_q, mode_d;
  logic signed [N-1:0] x_q, x_d;
  logic signed [N-1:0] y_q, y_d;
  logic signed [N-1:0] z_q, z_d;

  logic                dir_pos;
  logic signed [N-1:0] x_sh, y_sh;

  // Sign-filling right shift; a logical shift would corrupt negative values.
  function automatic logic signed [N-1:0] asr(input logic signed [N-1:0] v,
                                              input logic [4:0] s);
    return v >>> s;
  endfunction

  assign x_sh = asr(x_q, i_q);
  assign y_sh = asr(y_q, i_q);
  // d = +1: rotation when z >= 0, vectoring when y < 0.
  assign dir_pos = mode_q ? y_q[N-1] : ~z_q[N-1];

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          mode_d  = mode;
          i_d     = 5'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        // N-bit wrap-around arithmetic; caller bounds the operand range.
        if (dir_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_data;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_data;
        end
        if (i_q == LAST) begin
          i_d     = 5'd0;
          state_d = DONE;
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abort cancels everything except the data registers, which keep their values.
    if (abort) begin
      state_d = IDLE;
      i_d     = 5'd0;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= 5'd0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign atan_addr = (state_q == RUN) ? i_q : 5'd0;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign z_out     = z_q;

endmodule

// File: doc/cordic_seq.md
Name: cordic_seq

Overview:
Iterative CORDIC sequencer. Accepts one (x, y, z) operand set through a valid/ready handshake. Runs ITER micro-rotations, one per clock, over a single shared shift-add datapath, stepping the shift amount 0..ITER-1 and the arctangent table address in lockstep. Returns the result through a valid/ready handshake. Sits between the CORDIC front-end and the arctangent ROM, and supports both rotation mode (sin/cos) and vectoring mode (magnitude/angle).

Parameters:
N, 32, datapath width; x, y, z are signed two's complement Q3.(N-3), so 1.0 = 2^(N-3).
ITER, 16, number of micro-rotations; legal range 1..32, because the shift amount is 5 bits.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
abort  in  1  synchronous cancel; returns the block to IDLE
in_valid  in  1  operand valid
in_ready  out  1  high only in IDLE
mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); sampled on accept
x_in, y_in, z_in  in  N each  signed operands
atan_addr  out  5  current iteration index i
atan_data  in  N  atan(2^-i) in Q3.(N-3); combinational ROM, valid in the same cycle
out_valid  out  1  result valid
out_ready  in  1  consumer ready
x_out, y_out, z_out  out  N each  signed results, held stable while out_valid=1
busy  out  1  high in RUN or DONE

Behaviour:
- Reset:
  - Synchronous, active-high; state=IDLE, iteration counter i=0.
  - in_ready=1, out_valid=0, busy=0, atan_addr=0.
  - x/y/z registers and outputs = 0.
  - rst has priority over every other input.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid=1, load x, y, z and the mode register, set i=0, go to RUN.
  - RUN: i increments each cycle. On the edge where the update for i=ITER-1 is applied, go to DONE.
  - DONE: out_valid=1. When out_valid and out_ready are both high, go to IDLE.
- Back-to-back input: in_ready=0 outside IDLE, and in_valid is ignored there. A new operand can be accepted no earlier than the cycle after the output handshake, giving a throughput of 1 operation per ITER+2 cycles minimum.
- Latency: out_valid rises exactly ITER clock edges after the accepting edge.
- Per RUN cycle, with i = atan_addr:
  - Direction d = +1 in rotation mode when z >= 0; d = +1 in vectoring mode when y < 0; otherwise d = -1.
  - x' = x - d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*atan_data
- Arithmetic rules:
  - Right shifts are arithmetic (sign-filling); a logical shift is a bug.
  - Add and subtract are N-bit with wrap-around; there is no saturation.
  - The caller keeps |x|, |y| below 2^(N-1)/1.65 to avoid overflow; overflow beyond that is not detected.
- No gain compensation. Outputs carry the CORDIC gain K^-1 ≈ 1.64676 on x and y; the caller pre-scales.
- atan_addr equals i in RUN and is 0 in IDLE and DONE.
- abort: in any state it forces IDLE, clears out_valid and sets i=0 on the next edge. Data registers are left unchanged. If abort coincides with in_valid in IDLE, the operand is not accepted.
- out_ready held low: the block stays in DONE with outputs frozen indefinitely.
- ITER=1: the block spends one cycle in RUN.

Test Plan:
- Rotation: x_in=326016437 (K), y_in=0, z_in=421657428 (pi/4), mode=0 → after exactly 16 cycles, out_valid=1 with x_out≈y_out≈379625062 (±2^15) and |z_out| < 2^15.
- Negative angle: same operands with z_in=-421657428 → x_out≈379625062 and y_out≈-379625062 (±2^15). This checks the arithmetic shifts.
- Vectoring: x_in=y_in=536870912, z_in=0, mode=1 → z_out≈421657428 (±2^15), x_out≈1250302561 (±2^15), |y_out| < 2^15.
- Handshake:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0 throughout.
  - Pulse in_valid mid-RUN → ignored; result unchanged.
  - Release out_ready → block returns to IDLE the next cycle and accepts a new operand the following cycle.
- Abort and reset:
  - abort at i=5 → IDLE next cycle, out_valid never rises.
  - rst at i=7 → all outputs at reset values next cycle.
  - A subsequent operation after either event completes correctly.
- atan_addr sequence: trace shows 0,1,...,15 on consecutive RUN cycles and 0 otherwise.
